// File: rtl/laserdrop_ftdi_pkg.sv
// Shared types and constants for the FTDI 245-style FIFO responder.
//   byte_t          : one bus byte
//   rd_state_t      : read-strobe handshake states
//   wr_state_t      : write-strobe handshake states
//   FTDI_IDLE_LEVEL : inactive level of the active-low rd/wr strobes
//   DEFAULT_DEPTH   : default entries per byte FIFO
package laserdrop_ftdi_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DRIVE,
        RD_RECOV,
        RD_IGNORE
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_RECOV,
        WR_IGNORE
    } wr_state_t;

    localparam logic FTDI_IDLE_LEVEL = 1'b1;
    localparam int   DEFAULT_DEPTH   = 16;

endpackage

// File: rtl/ftdi_byte_fifo.sv
// Byte FIFO with wrap-bit pointers (log2(DEPTH)+1 bits each).
// Ports:
//   clk_i, rst_i      : clock, async active-high reset (flushes pointers)
//   push_i/push_data_i: write a byte at the tail
//   pop_i             : drop the head byte
//   head_o            : current head byte (0 while empty)
//   empty_o, full_o   : pointer-compare status
// A push while full is accepted only together with a pop, which makes it a
// pass-through replacement of the head.
module ftdi_byte_fifo
    import laserdrop_ftdi_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    byte_t       mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// FTDI-side emulation of the async 245 FIFO bus for running the LaserDrop
// core without an FTDI chip. Holds an rx FIFO (host -> core, drained by
// ftdi_rd) and a tx FIFO (core -> host, filled by ftdi_wr), and models read
// latency, post-strobe recovery and the rxf/txe flags.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   ftdi_rd_i, ftdi_wr_i         : active-low strobes from the core
//   rxf_o, txe_o                 : active-low "readable" / "writable" flags
//   adbus_in_i                   : bus value from the core during writes
//   adbus_out_o, adbus_oe_o      : read data and its drive enable
//   host_wr_*                    : valid/ready push into the rx FIFO
//   host_rd_*                    : valid/ready pop of the tx FIFO head
//   err_rd_empty_o, err_wr_full_o: sticky protocol-error flags
// Build option: define FTDI_SYNC_INPUTS_EN to pass both strobes through
// 2-flop synchronizers (adds 2 cycles of strobe latency).
module ftdi_fifo_responder
    import laserdrop_ftdi_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int RD_LAT = 2,
    parameter int RECOV  = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ftdi_rd_i,
    input  logic       ftdi_wr_i,
    output logic       rxf_o,
    output logic       txe_o,
    input  logic [7:0] adbus_in_i,
    output logic [7:0] adbus_out_o,
    output logic       adbus_oe_o,
    input  logic [7:0] host_wr_data_i,
    input  logic       host_wr_valid_i,
    output logic       host_wr_ready_o,
    output logic [7:0] host_rd_data_o,
    output logic       host_rd_valid_o,
    input  logic       host_rd_ready_i,
    output logic       err_rd_empty_o,
    output logic       err_wr_full_o
);

    localparam logic [7:0] RD_LAT_C = 8'(RD_LAT);
    localparam logic [7:0] RECOV_C  = 8'(RECOV);

    rd_state_t  rd_state_q;
    wr_state_t  wr_state_q;
    logic [7:0] rd_cnt_q;
    logic [7:0] wr_cnt_q;
    byte_t      wr_data_q;
    byte_t      adbus_out_q;
    logic       adbus_oe_q;
    logic       err_rd_empty_q;
    logic       err_wr_full_q;
    logic       init_q;   // low until the first edge after reset: holds flags inactive

    logic       rd_s, wr_s, rd_low, wr_low;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push, rx_pop, tx_push, tx_pop;
    byte_t      rx_head;

`ifdef FTDI_SYNC_INPUTS_EN
    logic [1:0] rd_sync_q;
    logic [1:0] wr_sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_sync_q <= {2{FTDI_IDLE_LEVEL}};
            wr_sync_q <= {2{FTDI_IDLE_LEVEL}};
        end else begin
            rd_sync_q <= {rd_sync_q[0], ftdi_rd_i};
            wr_sync_q <= {wr_sync_q[0], ftdi_wr_i};
        end
    end

    assign rd_s = rd_sync_q[1];
    assign wr_s = wr_sync_q[1];
`else
    assign rd_s = ftdi_rd_i;
    assign wr_s = ftdi_wr_i;
`endif

    assign rd_low = (rd_s != FTDI_IDLE_LEVEL);
    assign wr_low = (wr_s != FTDI_IDLE_LEVEL);

    assign rxf_o = !init_q || (rd_state_q == RD_RECOV) || rx_empty;
    assign txe_o = !init_q || (wr_state_q == WR_RECOV) || tx_full;

    assign host_wr_ready_o = init_q && !rx_full;
    assign host_rd_valid_o = !tx_empty;
    assign rx_push = host_wr_valid_i && host_wr_ready_o;
    assign tx_pop  = host_rd_ready_i && host_rd_valid_o;
    // A release during either RD_WAIT or RD_DRIVE consumes the byte.
    assign rx_pop  = !rd_low && ((rd_state_q == RD_WAIT) || (rd_state_q == RD_DRIVE));
    assign tx_push = !wr_low && (wr_state_q == WR_ACTIVE);

    assign adbus_out_o    = adbus_out_q;
    assign adbus_oe_o     = adbus_oe_q;
    assign err_rd_empty_o = err_rd_empty_q;
    assign err_wr_full_o  = err_wr_full_q;

    ftdi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rx_push),
        .push_data_i (host_wr_data_i),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .empty_o     (rx_empty),
        .full_o      (rx_full)
    );

    ftdi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (tx_push),
        .push_data_i (wr_data_q),
        .pop_i       (tx_pop),
        .head_o      (host_rd_data_o),
        .empty_o     (tx_empty),
        .full_o      (tx_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_q         <= 1'b0;
            rd_state_q     <= RD_IDLE;
            rd_cnt_q       <= '0;
            adbus_oe_q     <= 1'b0;
            adbus_out_q    <= '0;
            err_rd_empty_q <= 1'b0;
            wr_state_q     <= WR_IDLE;
            wr_cnt_q       <= '0;
            wr_data_q      <= '0;
            err_wr_full_q  <= 1'b0;
        end else begin
            init_q    <= 1'b1;
            // Sampled every cycle; on the release edge this still holds the
            // bus value from the previous (last low) cycle, which is pushed.
            wr_data_q <= adbus_in_i;

            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_low) begin
                        if (!rxf_o) begin
                            rd_state_q <= RD_WAIT;
                            rd_cnt_q   <= 8'd1;
                        end else begin
                            err_rd_empty_q <= 1'b1;
                            rd_state_q     <= RD_IGNORE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (!rd_low) begin
                        rd_state_q <= RD_RECOV;
                        rd_cnt_q   <= 8'd1;
                    end else if (rd_cnt_q == RD_LAT_C) begin
                        rd_state_q  <= RD_DRIVE;
                        adbus_oe_q  <= 1'b1;
                        adbus_out_q <= rx_head;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                    end
                end
                RD_DRIVE: begin
                    if (!rd_low) begin
                        adbus_oe_q <= 1'b0;
                        rd_state_q <= RD_RECOV;
                        rd_cnt_q   <= 8'd1;
                    end
                end
                RD_RECOV: begin
                    if (rd_cnt_q == RECOV_C) rd_state_q <= RD_IDLE;
                    else                     rd_cnt_q   <= rd_cnt_q + 8'd1;
                end
                RD_IGNORE: begin
                    if (!rd_low) rd_state_q <= RD_IDLE;
                end
                default: rd_state_q <= RD_IDLE;
            endcase

            case (wr_state_q)
                WR_IDLE: begin
                    if (wr_low) begin
                        // A write starting together with a read loses.
                        if (txe_o || (rd_state_q == RD_IDLE && rd_low)) begin
                            err_wr_full_q <= 1'b1;
                            wr_state_q    <= WR_IGNORE;
                        end else begin
                            wr_state_q <= WR_ACTIVE;
                        end
                    end
                end
                WR_ACTIVE: begin
                    if (!wr_low) begin
                        wr_state_q <= WR_RECOV;
                        wr_cnt_q   <= 8'd1;
                    end
                end
                WR_RECOV: begin
                    if (wr_cnt_q == RECOV_C) wr_state_q <= WR_IDLE;
                    else                     wr_cnt_q   <= wr_cnt_q + 8'd1;
                end
                WR_IGNORE: begin
                    if (!wr_low) wr_state_q <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ftdi_fifo_responder.md
Name: ftdi_fifo_responder

Overview:
- Emulates the FTDI side of the async 245-style FIFO bus: rxf, txe, ftdi_rd, ftdi_wr and the 8-bit adbus.
- Lets the LaserDrop core run against on-FPGA loopback or a host-side stream, with no FTDI chip fitted.
- Holds two byte FIFOs:
  - rx path: host to core, drained by ftdi_rd.
  - tx path: core to host, filled by ftdi_wr.
- Models the FT245 handshake timing: read latency, recovery precharge, and full/empty flags.

Parameters:
- DEPTH, 16: entries per FIFO; power of two, minimum 2.
- RD_LAT, 2: cycles from ftdi_rd first sampled low to adbus_oe/data valid; minimum 1.
- RECOV, 3: cycles rxf/txe are forced high after a completed read/write strobe; minimum 1.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ftdi_rd, in, 1: read strobe from core, active-low.
- ftdi_wr, in, 1: write strobe from core, active-low.
- rxf, out, 1: low = rx FIFO has a byte readable.
- txe, out, 1: low = tx FIFO can accept a byte.
- adbus_in, in, 8: bus value driven by core during writes.
- adbus_out, out, 8: read data.
- adbus_oe, out, 1: responder drives bus.
- host_wr_data, in, 8: host byte into rx FIFO.
- host_wr_valid, in, 1: host byte valid.
- host_wr_ready, out, 1: rx FIFO not full.
- host_rd_data, out, 8: tx FIFO head.
- host_rd_valid, out, 1: tx FIFO not empty.
- host_rd_ready, in, 1: host pops tx head.
- err_rd_empty, out, 1: sticky; read strobe while rxf high.
- err_wr_full, out, 1: sticky; write strobe while txe high, or simultaneous rd/wr.

Behaviour:
- Reset values:
  - rxf=1, txe=1, adbus_oe=0, adbus_out=0.
  - host_wr_ready=0, host_rd_valid=0, both err flags 0.
  - Both FIFOs empty, both FSMs idle.
- Reset mid-operation aborts any strobe cycle and flushes both FIFOs. First cycle after reset: txe=0, host_wr_ready=1.
- Host side uses a valid/ready transfer on the clock edge where both are high:
  - host_wr pushes into the rx FIFO.
  - host_rd pops the tx FIFO.
  - host_rd_data is the registered FIFO head and is valid whenever host_rd_valid=1.
- Read FSM: RD_IDLE -> RD_WAIT -> RD_DRIVE -> RD_RECOV.
  - RD_IDLE: ftdi_rd sampled low with rxf=0 -> RD_WAIT with counter=1.
  - RD_IDLE: ftdi_rd sampled low with rxf=1 -> set err_rd_empty, go to RD_IGNORE (adbus_oe stays 0). Leave RD_IGNORE when ftdi_rd returns high.
  - RD_WAIT: at counter==RD_LAT go to RD_DRIVE. adbus_oe=1 and adbus_out=rx head are registered in that same cycle, so they are visible RD_LAT cycles after the first low sample.
  - RD_DRIVE: hold data while ftdi_rd is low. When ftdi_rd is sampled high: pop rx FIFO, adbus_oe=0 next cycle, go to RD_RECOV.
  - ftdi_rd released during RD_WAIT: treat identically (pop, RD_RECOV).
  - RD_RECOV: rxf=1 for RECOV cycles, then RD_IDLE.
  - Outside RD_RECOV: rxf = rx FIFO empty.
- Write FSM: WR_IDLE -> WR_ACTIVE -> WR_RECOV.
  - WR_IDLE: ftdi_wr sampled low with txe=0 -> WR_ACTIVE.
  - WR_IDLE: ftdi_wr sampled low with txe=1 -> set err_wr_full, byte discarded, go to WR_IGNORE until ftdi_wr is high.
  - WR_ACTIVE: adbus_in is registered every cycle. On the first ftdi_wr high sample, push the value from the last low cycle and go to WR_RECOV.
  - WR_RECOV: txe=1 for RECOV cycles.
  - Outside WR_RECOV: txe = tx FIFO full.
- ftdi_rd and ftdi_wr first sampled low in the same cycle while both FSMs are idle:
  - The read proceeds per the rules above.
  - The write is ignored and err_wr_full is set.
- A host push into an empty rx FIFO makes rxf=0 on the following cycle, unless the read FSM is in RD_RECOV.
- FIFO pointers are log2(DEPTH)+1 bits with a wrap bit; full/empty come from pointer compare. Simultaneous push and pop is legal in any state, including full, where it is a pass-through replacement.
- Err flags clear only on reset.

Optional Feature:
- FTDI_SYNC_INPUTS_EN defined:
  - ftdi_rd and ftdi_wr each pass through a 2-flop synchronizer, reset value 1. All "sampled" references above use the synchronized value.
  - Read latency becomes RD_LAT+2 from the raw edge.
  - adbus_in is captured from the raw bus one cycle before the synchronized rising edge is seen.
- Undefined: strobes are used directly as same-clock signals, with the latencies stated above.

Decomposition:
- Package laserdrop_ftdi_pkg holds:
  - byte_t (logic [7:0]).
  - Enums rd_state_t {RD_IDLE, RD_WAIT, RD_DRIVE, RD_RECOV, RD_IGNORE} and wr_state_t {WR_IDLE, WR_ACTIVE, WR_RECOV, WR_IGNORE}.
  - Constants FTDI_IDLE_LEVEL=1'b1 and the default DEPTH.
- One sub-module ftdi_byte_fifo (parameter DEPTH), instantiated twice.

Test Plan:
- Host pushes 0xA5. Core pulls ftdi_rd low at cycle 0 and releases it at cycle 5. Required:
  - rxf=0 before the strobe.
  - adbus_oe=1 and adbus_out=0xA5 from cycle 2 (RD_LAT=2).
  - adbus_oe=0 at cycle 6.
  - rxf=1 for 3 cycles, then stays 1 (FIFO empty).
- Core drives adbus_in=0x3C with ftdi_wr low for 2 cycles, then high. Required:
  - host_rd_valid=1 with host_rd_data=0x3C.
  - txe=1 for 3 cycles after the rising sample, then 0.
- Fill tx FIFO with 16 writes. Required: txe stays 1 after recovery. A 17th strobe sets err_wr_full and host sees only 16 bytes. Pop one, then txe=0.
- Strobe ftdi_rd with rx FIFO empty. Required: adbus_oe stays 0, err_rd_empty=1, FIFO pointers unchanged.
- Assert reset during RD_DRIVE holding 0x11. Required: adbus_oe=0 and rxf=1 immediately (async); after release, rx FIFO is empty and no pop error is flagged.
- Assert ftdi_rd and ftdi_wr low in the same cycle with rx FIFO holding 0x77. Required: read returns 0x77, tx FIFO stays empty, err_wr_full=1.
